byte_accum_ctrl: RTL and testbench
==================================

BYTE_ACCUM_CTRL -- requirements
Module: byte_accum_ctrl

Interface
REQ-001 The block SHALL use one clock and asynchronous, active-high reset: clk_in posedge-triggered; reset_in asynchronous, active-high.
REQ-002 Port clk_in  input  1  system clock, all state updates on rising edge.
REQ-003 Port reset_in  input  1  asynchronous active-high reset.
REQ-004 Port start_in  input  1  single-cycle request to begin a new accumulation.
REQ-005 Port len_in  input  4  byte count for the burst; 1-15 literal, 0 means 16.
REQ-006 Port data_in  input  8  operand byte from upstream source.
REQ-007 Port data_valid_in  input  1  data_in is valid this cycle.
REQ-008 Port data_ready_out  output  1  block accepts data_in this cycle.
REQ-009 Port add_a_out  output  8  a-operand to the external 8-bit ripple adder.
REQ-010 Port add_b_out  output  8  b-operand to the external 8-bit ripple adder.
REQ-011 Port add_cin_out  output  1  carry-in to the external adder.
REQ-012 Port add_sum_in  input  8  sum returned by the external adder (combinational, same cycle).
REQ-013 Port add_cout_in  input  1  carry-out returned by the external adder.
REQ-014 Port result_out  output  16  accumulated total {acc_hi, acc_lo}.
REQ-015 Port result_valid_out  output  1  result_out holds a completed total.
REQ-016 Port result_ready_in  input  1  downstream consumes result this cycle.
REQ-017 Port busy_out  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCUM, DONE; state encoding is implementation choice.
REQ-019 IDLE: start_in=1 SHALL latch remaining count (len_in, 0 -> 16), clear acc_lo and acc_hi to 0, and move to ACCUM next cycle.
REQ-020 IDLE with start_in=0 SHALL hold state and outputs.
REQ-021 data_ready_out SHALL be 1 only in ACCUM; 0 in IDLE and DONE.
REQ-022 add_a_out SHALL equal acc_lo, add_b_out SHALL equal data_in, add_cin_out SHALL be constant 0.
REQ-023 A handshake SHALL occur when data_valid_in=1 and data_ready_out=1 in the same cycle.
REQ-024 On handshake: acc_lo <= add_sum_in; acc_hi <= acc_hi + add_cout_in (16-bit total modulo 2^16, cannot overflow for 16 bytes max 4080); remaining <= remaining - 1.
REQ-025 ACCUM without handshake SHALL hold acc_lo, acc_hi, remaining unchanged (stall any number of cycles).
REQ-026 Handshake with remaining=1 SHALL perform the final update and move to DONE next cycle.
REQ-027 DONE: result_valid_out=1, result_out stable; on result_ready_in=1 move to IDLE next cycle, result_valid_out drops.
REQ-028 result_out SHALL continue to show the last total in IDLE until the next start_in clears it.
REQ-029 start_in in ACCUM or DONE SHALL be ignored (no restart, no effect on count).
REQ-030 start_in in the same cycle DONE exits (result_ready_in=1) SHALL be ignored; a new start requires IDLE.
REQ-031 Latency: first byte accepted no earlier than 1 cycle after start_in; result_valid_out asserts 1 cycle after the final handshake.
REQ-032 busy_out SHALL be 1 in ACCUM and DONE, 0 in IDLE.

Reset
REQ-033 reset_in=1 SHALL immediately (no clock needed) force IDLE, acc_lo=0, acc_hi=0, remaining=0.
REQ-034 Reset values: data_ready_out=0, result_valid_out=0, busy_out=0, result_out=16'h0000, add_a_out=8'h00, add_cin_out=0.
REQ-035 Reset asserted mid-ACCUM or in DONE SHALL abandon the burst; no result is presented after release.
REQ-036 After reset release the block SHALL accept start_in on the first rising edge.

Verification
REQ-037 len_in=3, bytes 0x10,0x20,0x30 back-to-back -> result_out=16'h0060, result_valid_out 1 cycle after third handshake.
REQ-038 len_in=0, sixteen bytes 0xFF -> result_out=16'h0FF0, acc_hi increments on every carry.
REQ-039 len_in=2, bytes 0xF0,0x20 with data_valid_in low 5 cycles between -> result_out=16'h0110, no update during stall.
REQ-040 DONE with result_ready_in held 0 for 10 cycles, start_in pulsed -> result_valid_out stays 1, result unchanged, no restart.
REQ-041 len_in=4, reset_in pulsed after 2nd handshake -> all outputs at reset values; new start len_in=1, byte 0x05 -> result_out=16'h0005.

Source files
------------

// File: rtl/byte_accum_ctrl.sv
// byte_accum_ctrl: accumulates a burst of 1-16 bytes through an external 8-bit adder into a 16-bit total
//   clk_in, reset_in (async, active-high)
//   start_in, len_in            : begin a burst of len_in bytes (0 means 16)
//   data_in/valid/ready         : byte stream, accepted while accumulating
//   add_a/b/cin_out, add_sum/cout_in : external adder operands and its combinational result
//   result_out/valid/ready      : completed total handshake
//   busy_out                    : high while a burst is in flight or its result is pending
module byte_accum_ctrl (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        start_in,
    input  logic [3:0]  len_in,
    input  logic [7:0]  data_in,
    input  logic        data_valid_in,
    output logic        data_ready_out,
    output logic [7:0]  add_a_out,
    output logic [7:0]  add_b_out,
    output logic        add_cin_out,
    input  logic [7:0]  add_sum_in,
    input  logic        add_cout_in,
    output logic [15:0] result_out,
    output logic        result_valid_out,
    input  logic        result_ready_in,
    output logic        busy_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0] state;
    logic [7:0] acc_lo;
    logic [7:0] acc_hi;
    logic [4:0] remaining;
    logic       hs;
    assign data_ready_out   = state == ACCUM;
    assign result_valid_out = state == DONE;
    assign busy_out         = state != IDLE;
    assign hs               = data_valid_in & data_ready_out;
    assign add_a_out        = acc_lo;
    assign add_b_out        = data_in;
    assign add_cin_out      = 1'b0;
    assign result_out       = {acc_hi, acc_lo};
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= IDLE;
            acc_lo    <= 8'h00;
            acc_hi    <= 8'h00;
            remaining <= 5'd0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    state     <= ACCUM;
                    acc_lo    <= 8'h00;
                    acc_hi    <= 8'h00;
                    remaining <= (len_in == 4'd0) ? 5'd16 : {1'b0, len_in};
                end
                ACCUM: if (hs) begin
                    // each adder carry out of the low byte bumps the high byte
                    acc_lo    <= add_sum_in;
                    acc_hi    <= acc_hi + {7'd0, add_cout_in};
                    remaining <= remaining - 5'd1;
                    if (remaining == 5'd1) state <= DONE;
                end
                DONE: if (result_ready_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_accum_ctrl.sv
// tb_byte_accum_ctrl: randomized and directed check of byte_accum_ctrl against a burst-sum model
module tb_byte_accum_ctrl;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [3:0]  len_in = 4'd0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid_in = 1'b0;
    logic        data_ready_out;
    logic [7:0]  add_a_out;
    logic [7:0]  add_b_out;
    logic        add_cin_out;
    logic [7:0]  add_sum_in;
    logic        add_cout_in;
    logic [15:0] result_out;
    logic        result_valid_out;
    logic        result_ready_in = 1'b0;
    logic        busy_out;
    logic [8:0]  add_full;
    int total = 0;
    int bad = 0;
    bit m_act = 0;
    bit m_done = 0;
    int m_left = 0;
    int m_sum = 0;

    byte_accum_ctrl dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .len_in(len_in),
        .data_in(data_in), .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .add_a_out(add_a_out), .add_b_out(add_b_out), .add_cin_out(add_cin_out),
        .add_sum_in(add_sum_in), .add_cout_in(add_cout_in), .result_out(result_out),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in), .busy_out(busy_out)
    );

    // external ripple adder stand-in
    assign add_full    = {1'b0, add_a_out} + {1'b0, add_b_out} + {8'd0, add_cin_out};
    assign add_sum_in  = add_full[7:0];
    assign add_cout_in = add_full[8];

    always #5 clk_in = ~clk_in;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] s;
        s = m_sum[15:0];
        chk("ready", {15'd0, data_ready_out}, {15'd0, m_act});
        chk("busy", {15'd0, busy_out}, {15'd0, m_act | m_done});
        chk("valid", {15'd0, result_valid_out}, {15'd0, m_done});
        chk("result", result_out, s);
        chk("add_a", {8'd0, add_a_out}, {8'd0, s[7:0]});
        chk("add_b", {8'd0, add_b_out}, {8'd0, data_in});
        chk("cin", {15'd0, add_cin_out}, 16'd0);
    endtask

    task automatic model_zero();
        m_act = 0; m_done = 0; m_left = 0; m_sum = 0;
    endtask

    // one clock: model advances on the edge from the inputs held across it, compare on the falling edge
    task automatic cyc();
        @(posedge clk_in);
        if (reset_in) model_zero();
        else if (m_act) begin
            if (data_valid_in) begin
                m_sum += data_in;
                m_left--;
                if (m_left == 0) begin m_act = 0; m_done = 1; end
            end
        end else if (m_done) begin
            if (result_ready_in) m_done = 0;
        end else if (start_in) begin
            m_left = (len_in == 0) ? 16 : int'(len_in);
            m_sum = 0;
            m_act = 1;
        end
        @(negedge clk_in);
        check_all();
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        #1;
        model_zero();
        check_all();
        cyc();
        reset_in = 1'b0;
    endtask

    task automatic start(input logic [3:0] l);
        start_in = 1'b1; len_in = l;
        cyc();
        start_in = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        data_valid_in = 1'b1; data_in = b;
        cyc();
        data_valid_in = 1'b0;
    endtask

    initial begin
        @(negedge clk_in);
        do_reset();
        chk("rst_result", result_out, 16'h0000);
        chk("rst_busy", {15'd0, busy_out}, 16'd0);
        // three bytes back to back
        start(4'd3);
        feed(8'h10); feed(8'h20); feed(8'h30);
        chk("t1_valid", {15'd0, result_valid_out}, 16'd1);
        chk("t1_result", result_out, 16'h0060);
        result_ready_in = 1'b1; cyc(); result_ready_in = 1'b0;
        chk("t1_hold_idle", result_out, 16'h0060);
        cyc();
        // sixteen 0xFF bytes
        start(4'd0);
        for (int i = 0; i < 16; i++) feed(8'hFF);
        chk("t2_result", result_out, 16'h0FF0);
        result_ready_in = 1'b1; cyc(); result_ready_in = 1'b0;
        // stalled burst
        start(4'd2);
        feed(8'hF0);
        for (int i = 0; i < 5; i++) begin data_in = 8'($urandom); cyc(); end
        chk("t3_stall", result_out, 16'h00F0);
        feed(8'h20);
        chk("t3_result", result_out, 16'h0110);
        // DONE held with start pulsed, then start coincident with exit
        for (int i = 0; i < 10; i++) begin
            start_in = (i == 3); len_in = 4'd5;
            cyc();
        end
        start_in = 1'b0;
        chk("t4_valid", {15'd0, result_valid_out}, 16'd1);
        chk("t4_result", result_out, 16'h0110);
        result_ready_in = 1'b1; start_in = 1'b1; cyc();
        result_ready_in = 1'b0; start_in = 1'b0;
        chk("t4_no_restart", {15'd0, busy_out}, 16'd0);
        cyc();
        // reset mid-burst
        start(4'd4);
        feed(8'h11); feed(8'h22);
        do_reset();
        chk("t5_rst_result", result_out, 16'h0000);
        chk("t5_rst_valid", {15'd0, result_valid_out}, 16'd0);
        start(4'd1);
        feed(8'h05);
        chk("t5_result", result_out, 16'h0005);
        result_ready_in = 1'b1; cyc(); result_ready_in = 1'b0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start_in = ($urandom_range(0, 3) == 0);
            len_in = 4'($urandom);
            data_in = 8'($urandom);
            data_valid_in = ($urandom_range(0, 2) != 0);
            result_ready_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
